eeprom_arbiter: RTL and testbench
=================================

EEPROM_ARBITER -- requirements
Module: eeprom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters.
REQ-002 Parameter ADDR_W, default 11: EEPROM address width.
REQ-003 Parameter DATA_W, default 32: EEPROM read data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000: wait limit for ee_data_ready_i.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 req_i  in  NUM_REQ  per-requester read request, level, held until own ack.
REQ-008 req_addr_i  in  NUM_REQ*ADDR_W  per-requester address, slice i belongs to requester i.
REQ-009 ack_o  out  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-010 rsp_data_o  out  DATA_W  read data, valid while any ack_o bit is high.
REQ-011 rsp_err_o  out  1  timeout flag, valid while any ack_o bit is high.
REQ-012 busy_o  out  1  high whenever the state is not IDLE.
REQ-013 ee_read_o  out  1  one-cycle read strobe to the EEPROM reader.
REQ-014 ee_addr_o  out  ADDR_W  address to the EEPROM reader, stable from strobe until completion.
REQ-015 ee_data_i  in  DATA_W  EEPROM reader data.
REQ-016 ee_data_ready_i  in  1  EEPROM reader completion pulse.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: if any req_i bit is high, the FSM SHALL grant one requester, latch its index and address, and go to ISSUE; otherwise it stays in IDLE.
REQ-019 Grant SHALL be round-robin: first set req_i bit at or above ptr, wrapping from NUM_REQ-1 to 0.
REQ-020 ISSUE: ee_read_o SHALL be high for exactly this one cycle, with ee_addr_o equal to the latched address; the next state is WAIT and the timer is cleared.
REQ-021 WAIT: when ee_data_ready_i is sampled high, the FSM SHALL latch ee_data_i, clear the error flag, and go to DONE.
REQ-022 WAIT: when the timer reaches TIMEOUT_CYCLES-1 without ready, the FSM SHALL set the error flag, drive rsp_data_o to 0, and go to DONE.
REQ-023 If ready and timeout occur in the same cycle, ready SHALL win and no error is flagged.
REQ-024 DONE: ack_o[granted] SHALL be high for this one cycle only; ptr becomes (granted+1) mod NUM_REQ; the next state is IDLE.
REQ-025 ee_data_ready_i SHALL be ignored in IDLE, ISSUE and DONE.
REQ-026 If a requester drops req_i mid-transaction, the transaction SHALL still complete and its ack SHALL still pulse.
REQ-027 Latency: with req_i high at edge k in IDLE, ee_read_o is high in cycle k+1; ack_o is high in the cycle after ready is sampled.
REQ-028 A requester clears req_i on the edge where it samples ack_o; the arbiter SHALL NOT re-grant it from that stale request.
REQ-029 The timer SHALL be wide enough to hold TIMEOUT_CYCLES and SHALL saturate rather than wrap.

Reset
REQ-030 While reset_n is low, the FSM SHALL be in IDLE, with ptr, timer, latched index, address, data and error all 0.
REQ-031 While reset_n is low, every output SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no ack; a late ee_data_ready_i after reset release is ignored per REQ-025.

Structure
REQ-033 Package eeprom_arb_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-034 Round-robin selection SHALL live in one combinational sub-module, rr_pick (inputs: request vector and ptr; outputs: valid and index).

Verification
REQ-035 Single request: req_i=3'b010, addr 0x000, ready after 5 cycles with data 0x0000002A -> one ee_read_o pulse with addr 0; then ack_o=3'b010, rsp_data_o=0x2A, rsp_err_o=0.
REQ-036 Contention: req_i=3'b111 held continuously -> grants follow 0,1,2,0; each ack is one-hot and ee_addr_o matches the granted slice.
REQ-037 Timeout: TIMEOUT_CYCLES=16, no ready -> ack 16 cycles after the WAIT entry with rsp_err_o=1, rsp_data_o=0; the next request proceeds normally.
REQ-038 Simultaneous ready and timeout in the same cycle -> rsp_err_o=0 and data is latched.
REQ-039 Reset pulled low in WAIT -> all outputs 0 and no ack; a ready pulse 2 cycles after release -> no ack, busy_o=0.
REQ-040 Stray ready in IDLE, and req dropped in WAIT -> no spurious ack in the first case; the single ack still pulses in the second.

Source files
------------

// File: rtl/eeprom_arbiter_pkg.sv
// eeprom_arb_pkg: shared types and defaults for the EEPROM read arbiter.
//   state_t       - arbiter FSM states
//   DEF_*         - default parameter values
//   idx_w()       - width of a requester index (at least 1 bit)
package eeprom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ        = 3;
  localparam int DEF_ADDR_W         = 11;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeprom_arbiter_if.sv
// eeprom_arbiter_if: requester-side and EEPROM-reader-side signals of the arbiter.
//   slave  - arbiter view (consumes requests/reader data, drives acks/strobe)
//   master - environment view (requesters plus EEPROM reader)
interface eeprom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        ack_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      rsp_err_o;
  logic                      busy_o;
  logic                      ee_read_o;
  logic [ADDR_W-1:0]         ee_addr_o;
  logic [DATA_W-1:0]         ee_data_i;
  logic                      ee_data_ready_i;

  modport slave (
    input  req_i, req_addr_i, ee_data_i, ee_data_ready_i,
    output ack_o, rsp_data_o, rsp_err_o, busy_o, ee_read_o, ee_addr_o
  );

  modport master (
    output req_i, req_addr_i, ee_data_i, ee_data_ready_i,
    input  ack_o, rsp_data_o, rsp_err_o, busy_o, ee_read_o, ee_addr_o
  );
endinterface

// File: rtl/eeprom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   - request vector
//   ptr   - highest-priority index this round
//   valid - any request set
//   idx   - first set request at or above ptr, wrapping to 0
module rr_pick
  import eeprom_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  // Scan offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter: shares one EEPROM reader among NUM_REQ requesters.
//   clk, reset_n - clock, async active-low reset
//   bus (slave)  - req_i/req_addr_i in, ack_o/rsp_data_o/rsp_err_o/busy_o out,
//                  ee_read_o/ee_addr_o to the reader, ee_data_i/ee_data_ready_i back
// One transaction at a time: IDLE grants round-robin, ISSUE strobes the reader,
// WAIT collects data or times out, DONE pulses the granted requester's ack.
module eeprom_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  eeprom_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gnt;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data;
  logic                 err;
  logic [TMR_W-1:0]     timer;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 rd_q;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req_i),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      addr  <= '0;
      data  <= '0;
      err   <= 1'b0;
      timer <= '0;
      ack_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= pick_idx;
            addr  <= bus.req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
            rd_q  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          rd_q  <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (bus.ee_data_ready_i) begin
            data  <= bus.ee_data_i;
            err   <= 1'b0;
            ack_q <= NUM_REQ'(1) << gnt;
            state <= DONE;
          end else if (timer == TMR_LAST) begin
            data  <= '0;
            err   <= 1'b1;
            ack_q <= NUM_REQ'(1) << gnt;
            state <= DONE;
          end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          ack_q <= '0;
          ptr   <= (gnt == IDX_LAST) ? '0 : gnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.ee_read_o  = rd_q;
  assign bus.busy_o     = (state != IDLE);
  assign bus.ee_addr_o  = addr;
  assign bus.rsp_data_o = data;
  assign bus.rsp_err_o  = err;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter (3 requesters, 16-cycle timeout).
// Inputs change and outputs are sampled on the falling edge.
module tb_eeprom_arbiter;
  import eeprom_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  eeprom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  eeprom_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"},  bus.ack_o,      0);
    chk({tag, "_rd"},   bus.ee_read_o,  0);
    chk({tag, "_busy"}, bus.busy_o,     0);
    chk({tag, "_data"}, bus.rsp_data_o, 0);
    chk({tag, "_err"},  bus.rsp_err_o,  0);
    chk({tag, "_addr"}, bus.ee_addr_o,  0);
  endtask

  // Bounded wait for the read strobe; a miss is reported as a failure.
  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ee_read_o !== 1'b1 && n < 8);
    chk({tag, "_rd"}, bus.ee_read_o, 1);
  endtask

  initial begin
    int exp_g[4];
    int early;
    exp_g = '{0, 1, 2, 0};

    reset_n             = 1'b0;
    bus.req_i           = '0;
    bus.req_addr_i      = '0;
    bus.ee_data_i       = '0;
    bus.ee_data_ready_i = 1'b0;
    tick();
    tick();
    chk_quiet("rst");
    reset_n = 1'b1;
    tick();

    // Single request from requester 1 at address 0.
    bus.req_addr_i = {11'h2AA, 11'h000, 11'h155};
    bus.req_i      = 3'b010;
    wait_rd("t1");
    chk("t1_addr", bus.ee_addr_o, 0);
    chk("t1_busy", bus.busy_o, 1);
    tick();
    chk("t1_rd_once", bus.ee_read_o, 0);
    repeat (3) tick();
    bus.ee_data_i       = 32'h0000_002A;
    bus.ee_data_ready_i = 1'b1;
    tick();
    bus.ee_data_ready_i = 1'b0;
    chk("t1_ack",  bus.ack_o, 3'b010);
    chk("t1_data", bus.rsp_data_o, 32'h2A);
    chk("t1_err",  bus.rsp_err_o, 0);
    bus.req_i = 3'b000;
    tick();
    chk("t1_ack_once", bus.ack_o, 0);
    chk("t1_idle", bus.busy_o, 0);

    // Contention from a fresh pointer: grants go 0,1,2,0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req_addr_i = {11'h303, 11'h202, 11'h101};
    bus.req_i      = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_rd($sformatf("t2_%0d", i));
      chk($sformatf("t2_addr_%0d", i), bus.ee_addr_o, 64'(11'h101 * (exp_g[i] + 1)));
      tick();
      bus.ee_data_i       = 32'hC0DE_0000 + 32'(i);
      bus.ee_data_ready_i = 1'b1;
      tick();
      bus.ee_data_ready_i = 1'b0;
      chk($sformatf("t2_ack_%0d", i), bus.ack_o, 64'(3'b001 << exp_g[i]));
      chk($sformatf("t2_data_%0d", i), bus.rsp_data_o, 64'(32'hC0DE_0000 + 32'(i)));
    end
    bus.req_i = 3'b000;
    tick();

    // Timeout: no ready; ack arrives 16 cycles after WAIT entry.
    bus.ee_data_i = 32'hDEAD_BEEF;
    bus.req_i     = 3'b001;
    wait_rd("t3");
    early = 0;
    for (int k = 0; k < TO; k++) begin
      tick();
      if (bus.ack_o !== 3'b000) early++;
    end
    chk("t3_no_early_ack", early, 0);
    tick();
    chk("t3_ack",  bus.ack_o, 3'b001);
    chk("t3_err",  bus.rsp_err_o, 1);
    chk("t3_data", bus.rsp_data_o, 0);
    bus.req_i = 3'b000;
    tick();

    // Normal request after the timeout.
    bus.req_i = 3'b100;
    wait_rd("t3b");
    chk("t3b_addr", bus.ee_addr_o, 11'h303);
    tick();
    bus.ee_data_i       = 32'h0000_1234;
    bus.ee_data_ready_i = 1'b1;
    tick();
    bus.ee_data_ready_i = 1'b0;
    chk("t3b_ack",  bus.ack_o, 3'b100);
    chk("t3b_err",  bus.rsp_err_o, 0);
    chk("t3b_data", bus.rsp_data_o, 32'h1234);
    bus.req_i = 3'b000;
    tick();

    // Ready lands in the same cycle the timer hits its last count.
    bus.req_i = 3'b010;
    wait_rd("t4");
    repeat (TO) tick();
    bus.ee_data_i       = 32'h5A5A_5A5A;
    bus.ee_data_ready_i = 1'b1;
    tick();
    bus.ee_data_ready_i = 1'b0;
    chk("t4_ack",  bus.ack_o, 3'b010);
    chk("t4_err",  bus.rsp_err_o, 0);
    chk("t4_data", bus.rsp_data_o, 32'h5A5A_5A5A);
    bus.req_i = 3'b000;
    tick();

    // Reset in WAIT aborts; a late ready after release is ignored.
    bus.req_i = 3'b001;
    wait_rd("t5");
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk_quiet("t5_rst");
    bus.req_i = 3'b000;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    bus.ee_data_i       = 32'h0000_0099;
    bus.ee_data_ready_i = 1'b1;
    tick();
    bus.ee_data_ready_i = 1'b0;
    chk("t5_no_ack", bus.ack_o, 0);
    chk("t5_idle",   bus.busy_o, 0);
    tick();
    chk("t5_no_ack2", bus.ack_o, 0);

    // Stray ready in IDLE.
    bus.ee_data_i       = 32'h0000_0055;
    bus.ee_data_ready_i = 1'b1;
    tick();
    bus.ee_data_ready_i = 1'b0;
    chk("t6_stray_ack",  bus.ack_o, 0);
    chk("t6_stray_busy", bus.busy_o, 0);

    // Request dropped while waiting still completes.
    bus.req_i = 3'b010;
    wait_rd("t6");
    chk("t6_addr", bus.ee_addr_o, 11'h202);
    tick();
    bus.req_i = 3'b000;
    tick();
    bus.ee_data_i       = 32'h0000_0077;
    bus.ee_data_ready_i = 1'b1;
    tick();
    bus.ee_data_ready_i = 1'b0;
    chk("t6_ack",  bus.ack_o, 3'b010);
    chk("t6_data", bus.rsp_data_o, 32'h77);
    tick();
    chk("t6_ack_once", bus.ack_o, 0);
    chk("t6_idle",     bus.busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
